// File: rtl/inst_encoder_if.sv
// Load-session bundle: host instruction stream, instruction-memory write port and status.
// The slave modport is the encoder's view; master is the host/memory side.
interface inst_encoder_if #(
   parameter int AW = 8
);
   logic          start;
   logic          in_valid;
   logic          in_ready;
   logic [3:0]    in_op;
   logic [11:0]   in_field;
   logic          in_last;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [15:0]   mem_wdata;
   logic          mem_ready;
   logic          busy;
   logic          done;
   logic          err;
   logic [AW:0]   word_count;

   modport slave (
      input  start, in_valid, in_op, in_field, in_last, mem_ready,
      output in_ready, mem_we, mem_addr, mem_wdata, busy, done, err, word_count
   );

   modport master (
      output start, in_valid, in_op, in_field, in_last, mem_ready,
      input  in_ready, mem_we, mem_addr, mem_wdata, busy, done, err, word_count
   );
endinterface

// File: rtl/inst_encoder.sv
// Packs {op, field} into 16-bit words, buffers them and writes instruction memory from address 0.
// One-cycle accept-to-write latency; in_ready drops on FIFO full or memory capacity, mem_ready low stalls writes.
module inst_encoder #(
   parameter int AW         = 8,
   parameter int FIFO_DEPTH = 4
) (
   input logic            clk,
   input logic            rst,
   inst_encoder_if.slave  bus
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam logic [AW+1:0] CAP = {2'b01, {AW{1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_t;

   state_t        state_q, state_d;
   logic [PW:0]   wr_ptr_q, wr_ptr_d;
   logic [PW:0]   rd_ptr_q, rd_ptr_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [AW:0]   count_q, count_d;
   logic          err_q, err_d;
   logic [15:0]   fifo_q [FIFO_DEPTH];
   logic [15:0]   fifo_d [FIFO_DEPTH];

   logic [PW:0]   fifo_count;
   logic          fifo_empty, fifo_full, cap_ok, active;
   logic          in_ready, mem_we, xfer, legal;
   logic [AW+1:0] cap_sum;
   logic [15:0]   head;

   always_comb begin
      fifo_count = wr_ptr_q - rd_ptr_q;
      fifo_empty = (fifo_count == '0);
      fifo_full  = (fifo_count == (PW+1)'(FIFO_DEPTH));
      // Buffered words count against capacity so the memory can never be overrun
      cap_sum    = {1'b0, count_q} + (AW+2)'(fifo_count);
      cap_ok     = (cap_sum < CAP);
      active     = (state_q == S_LOAD) || (state_q == S_DRAIN);
      in_ready   = (state_q == S_LOAD) && !fifo_full && cap_ok;
      mem_we     = active && !fifo_empty && bus.mem_ready;
      xfer       = bus.in_valid && in_ready;
      legal      = (bus.in_op != 4'd8) && (bus.in_op < 4'd13);
      head       = fifo_q[rd_ptr_q[PW-1:0]];
   end

   always_comb begin
      state_d  = state_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      addr_d   = addr_q;
      count_d  = count_q;
      err_d    = err_q;
      fifo_d   = fifo_q;

      if (xfer && legal) begin
         fifo_d[wr_ptr_q[PW-1:0]] = {bus.in_op, bus.in_field};
         wr_ptr_d = wr_ptr_q + (PW+1)'(1);
      end
      if (mem_we) begin
         rd_ptr_d = rd_ptr_q + (PW+1)'(1);
         addr_d   = addr_q + AW'(1);
         count_d  = count_q + (AW+1)'(1);
      end

      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               state_d  = S_LOAD;
               addr_d   = '0;
               count_d  = '0;
               err_d    = 1'b0;
               wr_ptr_d = '0;
               rd_ptr_d = '0;
            end
         end
         S_LOAD: begin
            if (xfer) begin
               if (!legal) err_d = 1'b1;
               if (bus.in_last) state_d = S_DRAIN;
            end else if (!cap_ok) begin
               // Memory filled before the host marked its last instruction
               state_d = S_DRAIN;
               err_d   = 1'b1;
            end
         end
         S_DRAIN: begin
            if (fifo_empty || ((fifo_count == (PW+1)'(1)) && mem_we)) state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         addr_q   <= '0;
         count_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         addr_q   <= addr_d;
         count_q  <= count_d;
         err_q    <= err_d;
      end
   end

   // Storage needs no reset: the read side is masked whenever the buffer is empty
   always_ff @(posedge clk) begin
      fifo_q <= fifo_d;
   end

   assign bus.in_ready   = in_ready;
   assign bus.mem_we     = mem_we;
   assign bus.mem_addr   = addr_q;
   assign bus.mem_wdata  = fifo_empty ? 16'h0000 : head;
   assign bus.busy       = active;
   assign bus.done       = (state_q == S_DONE);
   assign bus.err        = err_q;
   assign bus.word_count = count_q;
endmodule

// File: tb/tb_inst_encoder.sv
// Self-checking bench for inst_encoder: directed vector table, multi-cycle corner sequences,
// and randomized sessions checked cycle by cycle against a queue-based reference model.
module tb_inst_encoder;
   localparam int CAP   = 256;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   inst_encoder_if #(.AW(8)) bus ();
   inst_encoder_if #(.AW(3)) bus3 ();

   inst_encoder #(.AW(8), .FIFO_DEPTH(4)) dut  (.clk(clk), .rst(rst), .bus(bus));
   inst_encoder #(.AW(3), .FIFO_DEPTH(4)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

   int checks = 0;
   int errors = 0;
   int cycle  = 0;
   always @(posedge clk) cycle = cycle + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic bit is_legal(input logic [3:0] op);
      return !(op inside {4'd8, 4'd13, 4'd14, 4'd15});
   endfunction

   // ---------------- reference model for the AW=8 instance ----------------
   logic [15:0] m_q[$];
   int m_wc;
   bit m_load, m_drain, m_done, m_err;

   typedef struct { logic [7:0] addr; logic [15:0] data; int cyc; } wr_t;
   wr_t cap_q[$];
   int done_cnt;

   always @(negedge clk) begin
      bit exp_rdy, exp_we;
      int qs, wc;
      if (rst) begin
         m_q.delete(); m_wc = 0; m_load = 0; m_drain = 0; m_done = 0; m_err = 0;
         chk("rst_in_ready", 32'(bus.in_ready), 0);
         chk("rst_mem_we", 32'(bus.mem_we), 0);
         chk("rst_mem_addr", 32'(bus.mem_addr), 0);
         chk("rst_mem_wdata", 32'(bus.mem_wdata), 0);
         chk("rst_busy", 32'(bus.busy), 0);
         chk("rst_done", 32'(bus.done), 0);
         chk("rst_err", 32'(bus.err), 0);
         chk("rst_word_count", 32'(bus.word_count), 0);
      end else begin
         qs = m_q.size();
         wc = m_wc;
         exp_rdy = m_load && (qs < DEPTH) && (wc + qs < CAP);
         exp_we  = (m_load || m_drain) && (qs > 0) && (bus.mem_ready === 1'b1);
         chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
         chk("mem_we", 32'(bus.mem_we), 32'(exp_we));
         if (exp_we) begin
            chk("mem_addr", 32'(bus.mem_addr), 32'(wc % CAP));
            chk("mem_wdata", 32'(bus.mem_wdata), 32'(m_q[0]));
         end
         chk("busy", 32'(bus.busy), 32'(m_load || m_drain));
         chk("done", 32'(bus.done), 32'(m_done));
         chk("err", 32'(bus.err), 32'(m_err));
         chk("word_count", 32'(bus.word_count), 32'(wc));
         if (bus.mem_we) cap_q.push_back('{bus.mem_addr, bus.mem_wdata, cycle});
         if (bus.done) done_cnt++;

         if (exp_we) begin
            m_q.delete(0);
            m_wc++;
         end
         if (m_done) m_done = 0;
         else if (m_load) begin
            if (bus.in_valid && exp_rdy) begin
               if (is_legal(bus.in_op)) m_q.push_back({bus.in_op, bus.in_field});
               else m_err = 1;
               if (bus.in_last) begin m_load = 0; m_drain = 1; end
            end else if (!(wc + qs < CAP)) begin
               m_load = 0; m_drain = 1; m_err = 1;
            end
         end else if (m_drain) begin
            if (m_q.size() == 0) begin m_drain = 0; m_done = 1; end
         end else if (bus.start) begin
            m_q.delete(); m_wc = 0; m_err = 0; m_load = 1;
         end
      end
   end

   // ---------------- AW=3 instance observer ----------------
   logic [2:0]  a3[$];
   logic [15:0] d3[$];
   int done3;
   always @(negedge clk) begin
      if (!rst) begin
         if (bus3.mem_we) begin a3.push_back(bus3.mem_addr); d3.push_back(bus3.mem_wdata); end
         if (bus3.done) done3++;
      end
   end

   // ---------------- helpers ----------------
   task automatic pulse_start();
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
   endtask

   task automatic send(input logic [3:0] op, input logic [11:0] f, input bit last);
      bus.in_valid = 1'b1; bus.in_op = op; bus.in_field = f; bus.in_last = last;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            @(posedge clk); #1;
            bus.in_valid = 1'b0; bus.in_last = 1'b0;
            return;
         end
      end
      chk("send_timeout", 1, 0);
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_done();
      bit seen = 0;
      for (int k = 0; k < 200 && !seen; k++) begin
         @(negedge clk);
         if (bus.done) seen = 1;
      end
      chk("done_seen", 32'(seen), 1);
      @(posedge clk); #1;
   endtask

   typedef struct {
      logic [3:0]  op;
      logic [11:0] field;
      bit          last;
      bit          wr;
      logic [15:0] word;
      logic [7:0]  addr;
   } vec_t;
   vec_t tbl[8];

   task automatic run_table(input int lo, input int hi, input bit exp_err, input bit consec);
      int idx = 0;
      cap_q.delete(); done_cnt = 0;
      pulse_start();
      for (int i = lo; i <= hi; i++) send(tbl[i].op, tbl[i].field, tbl[i].last);
      wait_done();
      for (int i = lo; i <= hi; i++) begin
         if (tbl[i].wr) begin
            if (idx < cap_q.size()) begin
               chk("tbl_wdata", 32'(cap_q[idx].data), 32'(tbl[i].word));
               chk("tbl_addr", 32'(cap_q[idx].addr), 32'(tbl[i].addr));
               if (consec) chk("tbl_consecutive", 32'(cap_q[idx].cyc - cap_q[0].cyc), 32'(idx));
            end
            idx++;
         end
      end
      chk("tbl_nwrites", 32'(cap_q.size()), 32'(idx));
      chk("tbl_err", 32'(bus.err), 32'(exp_err));
      chk("tbl_word_count", 32'(bus.word_count), 32'(idx));
      chk("tbl_done_pulses", 32'(done_cnt), 1);
   endtask

   initial begin
      int acc, seen_rdy, n_sent;
      bit fin;

      tbl[0] = '{4'd1,  12'h123, 1'b0, 1'b1, 16'h1123, 8'd0};
      tbl[1] = '{4'd2,  12'h010, 1'b0, 1'b1, 16'h2010, 8'd1};
      tbl[2] = '{4'd12, 12'hABC, 1'b1, 1'b1, 16'hCABC, 8'd2};
      tbl[3] = '{4'd3,  12'h001, 1'b0, 1'b1, 16'h3001, 8'd0};
      tbl[4] = '{4'd8,  12'h555, 1'b0, 1'b0, 16'h0000, 8'd0};
      tbl[5] = '{4'd4,  12'h002, 1'b0, 1'b1, 16'h4002, 8'd1};
      tbl[6] = '{4'd14, 12'h001, 1'b0, 1'b0, 16'h0000, 8'd0};
      tbl[7] = '{4'd9,  12'h0FF, 1'b1, 1'b1, 16'h90FF, 8'd2};

      rst = 1'b1;
      bus.start = 0; bus.in_valid = 0; bus.in_op = 0; bus.in_field = 0; bus.in_last = 0; bus.mem_ready = 1;
      bus3.start = 0; bus3.in_valid = 0; bus3.in_op = 0; bus3.in_field = 0; bus3.in_last = 0; bus3.mem_ready = 1;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_in_ready", 32'(bus.in_ready), 0);
      chk("reset_busy", 32'(bus.busy), 0);
      chk("reset_word_count", 32'(bus.word_count), 0);
      rst = 1'b0;
      @(posedge clk); #1;

      // basic session, then illegal opcodes mixed in
      run_table(0, 2, 1'b0, 1'b1);
      run_table(3, 7, 1'b1, 1'b0);

      // memory stall: exactly DEPTH words accepted, then release
      cap_q.delete();
      pulse_start();
      bus.mem_ready = 1'b0;
      for (int i = 0; i < 4; i++) send(4'd3, 12'(i), 1'b0);
      bus.in_valid = 1'b1; bus.in_op = 4'd3; bus.in_field = 12'd4; bus.in_last = 1'b0;
      seen_rdy = 0;
      repeat (6) begin
         @(negedge clk);
         if (bus.in_ready) seen_rdy++;
      end
      @(posedge clk); #1;
      chk("stall_ready_low", 32'(seen_rdy), 0);
      chk("stall_no_writes", 32'(cap_q.size()), 0);
      bus.mem_ready = 1'b1;
      send(4'd3, 12'd4, 1'b0);
      send(4'd3, 12'd5, 1'b1);
      wait_done();
      chk("stall_nwrites", 32'(cap_q.size()), 6);
      for (int i = 0; i < 6 && i < cap_q.size(); i++) begin
         chk("stall_wdata", 32'(cap_q[i].data), 32'(16'h3000 | 16'(i)));
         chk("stall_addr", 32'(cap_q[i].addr), 32'(i));
      end

      // capacity overflow on the AW=3 instance
      bus3.start = 1'b1;
      @(posedge clk); #1;
      bus3.start = 1'b0;
      acc = 0;
      for (int c = 0; c < 40; c++) begin
         bus3.in_valid = (acc < 9); bus3.in_op = 4'd1; bus3.in_field = 12'(acc);
         @(negedge clk);
         if (bus3.in_valid && bus3.in_ready) acc++;
         @(posedge clk); #1;
      end
      bus3.in_valid = 1'b0;
      chk("cap_accepted", 32'(acc), 8);
      chk("cap_nwrites", 32'(a3.size()), 8);
      for (int i = 0; i < 8 && i < a3.size(); i++) begin
         chk("cap_addr", 32'(a3[i]), 32'(i));
         chk("cap_wdata", 32'(d3[i]), 32'(16'h1000 | 16'(i)));
      end
      chk("cap_err", 32'(bus3.err), 1);
      chk("cap_done_pulses", 32'(done3), 1);
      chk("cap_word_count", 32'(bus3.word_count), 8);

      // reset while words are buffered
      pulse_start();
      bus.mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) send(4'd7, 12'hF00 | 12'(i), 1'b0);
      bus.mem_ready = 1'b1;
      #1;
      chk("pre_rst_mem_we", 32'(bus.mem_we), 1);
      rst = 1'b1;
      #1;
      chk("async_rst_mem_we", 32'(bus.mem_we), 0);
      chk("async_rst_busy", 32'(bus.busy), 0);
      chk("async_rst_in_ready", 32'(bus.in_ready), 0);
      chk("async_rst_wdata", 32'(bus.mem_wdata), 0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk); #1;
      cap_q.delete();
      pulse_start();
      send(4'd5, 12'h777, 1'b1);
      wait_done();
      chk("post_rst_nwrites", 32'(cap_q.size()), 1);
      if (cap_q.size() > 0) begin
         chk("post_rst_wdata", 32'(cap_q[0].data), 32'h5777);
         chk("post_rst_addr", 32'(cap_q[0].addr), 0);
      end

      // start pulse during LOAD is ignored
      cap_q.delete();
      pulse_start();
      send(4'd1, 12'hAAA, 1'b0);
      send(4'd2, 12'hBBB, 1'b0);
      pulse_start();
      send(4'd3, 12'hCCC, 1'b1);
      wait_done();
      chk("restart_nwrites", 32'(cap_q.size()), 3);
      if (cap_q.size() == 3) begin
         chk("restart_addr", 32'(cap_q[2].addr), 2);
         chk("restart_wdata", 32'(cap_q[2].data), 32'h3CCC);
      end
      chk("restart_word_count", 32'(bus.word_count), 3);

      // randomized sessions against the model
      for (int s = 0; s < 20; s++) begin
         pulse_start();
         n_sent = 0;
         fin = 0;
         for (int c = 0; c < 400 && !fin; c++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.in_op     = 4'($urandom_range(0, 15));
            bus.in_field  = 12'($urandom);
            bus.in_last   = (n_sent >= 20) || ($urandom_range(0, 15) == 0);
            bus.mem_ready = ($urandom_range(0, 3) != 0);
            bus.start     = ($urandom_range(0, 31) == 0);
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) n_sent++;
            if (bus.done) fin = 1;
            @(posedge clk); #1;
         end
         bus.in_valid = 0; bus.in_last = 0; bus.start = 0;
         chk("rand_session_end", 32'(fin), 1);
         if (!fin) begin
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
         end
         @(posedge clk); #1;
      end

      repeat (3) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/inst_encoder.md
# inst_encoder

Program loader that is the write side of the instruction path. It accepts instruction fields (4-bit opcode plus 12-bit register/address field) over a valid/ready stream and packs each into a 16-bit word as {op, field}. It buffers the words in a small FIFO and writes them sequentially into instruction memory from address 0. It rejects opcodes the datapath decoder does not implement and reports completion and errors to the host or VGA debug logic.

## Interface
Parameters:
- AW, 8, instruction memory address width; capacity is 2^AW words.
- FIFO_DEPTH, 4, number of entries in the encoded-word buffer; must be a power of two, 2 or more.

Ports:
- clk  input  1  single system clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a load session.
- in_valid  input  1  in_op, in_field and in_last are valid.
- in_ready  output  1  block accepts this cycle; a transfer occurs when in_valid and in_ready are both high at a clock edge.
- in_op  input  4  opcode.
- in_field  input  12  register/address field, packed unmodified.
- in_last  input  1  marks the final instruction of the session.
- mem_we  output  1  instruction memory write strobe.
- mem_addr  output  AW  write address.
- mem_wdata  output  16  encoded word, {in_op, in_field}.
- mem_ready  input  1  memory accepts a write this cycle.
- busy  output  1  high in LOAD and DRAIN.
- done  output  1  one-cycle pulse at session end.
- err  output  1  sticky error flag; cleared by start or rst.
- word_count  output  AW+1  number of words written this session.

## Operation
- The FSM has four states: IDLE, LOAD, DRAIN and DONE.
- IDLE: on start, mem_addr, word_count, err and the FIFO are cleared and the FSM enters LOAD. start is ignored in every other state.
- LOAD:
  - in_ready = !fifo_full && (word_count + fifo_count < 2^AW).
  - On each transfer the opcode is checked. Legal opcodes are 0, 1–7 and 9–12.
  - A legal opcode pushes {in_op, in_field} into the FIFO.
  - An illegal opcode (8, 13, 14, 15) is consumed without a push and sets err.
  - A transfer with in_last=1 moves the FSM to DRAIN, whether or not its opcode was legal.
  - If the capacity condition drops in_ready with no in_last accepted, the FSM moves to DRAIN and sets err.
- DRAIN: in_ready=0. Once the FIFO is empty, the FSM moves to DONE.
- DONE: done=1 for one cycle, then the FSM returns to IDLE.
- Write side, active in LOAD and DRAIN:
  - mem_we = !fifo_empty && mem_ready.
  - mem_wdata is the FIFO head and mem_addr is the write address register.
  - On a write edge the FIFO pops, and mem_addr and word_count increment.
  - mem_addr wraps to 0 only when word_count reaches 2^AW. No write occurs after that.
- A push and a pop in the same cycle are both performed; occupancy is unchanged.
- word_count holds its value through IDLE until the next start.

## Timing
- Reset values: in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, err=0, word_count=0, FIFO empty, state IDLE.
- in_ready goes high the cycle after start is sampled.
- Latency: a word accepted at edge N can be written at edge N+1 at the earliest. mem_we is high in the cycle between those edges if mem_ready is high.
- Sustained throughput is one word per cycle while in_valid and mem_ready are both held high.
- Stalls:
  - mem_ready low: mem_we=0 and all FIFO, address and count state holds. The FIFO fills and in_ready drops when it is full.
  - in_valid low in LOAD: no change.
- done asserts the cycle after the edge at which the final pop empties the FIFO in DRAIN. If the FIFO is already empty on entry, DRAIN lasts one cycle.
- rst mid-session: immediate return to the reset values; buffered words are discarded and mem_we drops asynchronously.

## Test plan
- Reset, start, then stream op=1/field=0x123, op=2/0x010, op=12/0xABC with last=1, mem_ready=1 -> mem writes 0x1123@0, 0x2010@1, 0xCABC@2 on consecutive cycles; done pulse; word_count=3; err=0.
- Stream containing op=8/0x555 and op=14/0x001 between legal words -> both consumed with no write; err=1; remaining addresses contiguous.
- mem_ready held low, 6 words offered -> exactly FIFO_DEPTH=4 accepted, then in_ready=0. Releasing mem_ready -> 4 writes, then the remaining 2 are accepted and written in order.
- AW=3, 9 legal words with no last -> 8 writes at 0–7, the 9th never accepted, err=1, done pulse, word_count=8.
- Assert rst while 3 words are buffered and mem_ready=0 -> all outputs return to reset values at once; a later start writes from address 0 and no stale word appears.
- Pulse start during LOAD -> ignored; address and count are not cleared.
